wb_mmio_unit: RTL and testbench
===============================

# wb_mmio_unit

Writeback stage unit for the RISC-V core. It replaces the purely combinational writeback decode with a registered writeback stage. It selects ALU, PC+4, DMEM or MMIO load data, performs byte/half extraction and extension, and drives the register-file write port. Unlike the previous decoder, it supports N variable-latency MMIO read devices via a request/response handshake with timeout, and stalls upstream while an MMIO load is outstanding.

## Interface
- XLEN, 32, data/address width
- N_DEV, 2, number of MMIO read devices (≥1)
- DEV_LSB, 4, lowest address bit of device index field
- TIMEOUT_CYC, 255, max WAIT cycles before bus error (≥1)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  MEM stage presents instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction
- in_addr  in  XLEN  ALU result used as memory address
- in_alu  in  XLEN  ALU result
- in_pc4  in  XLEN  PC+4
- dmem_dout  in  XLEN  synchronous DMEM read data, valid the cycle after acceptance
- mmio_req  out  N_DEV  one-hot, one-cycle read request
- mmio_addr  out  XLEN  captured address
- mmio_rdata  in  N_DEV*XLEN  device i data at [i*XLEN +: XLEN]
- mmio_rvalid  in  N_DEV  device i response strobe
- rf_we  out  1  register write enable
- rf_waddr  out  5  destination register (inst[11:7])
- rf_wdata  out  XLEN  write data
- bus_err  out  1  one-cycle pulse: misaligned load, bad device index, or timeout

## Operation
- Accept when in_valid && in_ready; capture inst, addr, alu, pc4 into stage registers and set stage_valid. Without an accept, stage_valid clears next cycle.
- Write class: R/I-ALU, LUI, AUIPC → alu; JAL/JALR → pc4; LOAD → memory; STORE, BRANCH and unknown opcodes → no write.
- rf_we = 0 whenever rd == 0.
- A load is MMIO if addr[31] = 1. Device index = addr[DEV_LSB +: $clog2(N_DEV)]. If index ≥ N_DEV: no request, bus_err at T+1, no write.
- Load extraction by funct3 and addr[1:0]:
  - LB/LBU select the byte and extend it (sign for LB, zero for LBU).
  - LH/LHU select the half at addr[1] and extend it.
  - LW passes the word through.
  - Misaligned accesses (half with addr[0] = 1, word with addr[1:0] ≠ 0) → bus_err, no write, no MMIO request.
- FSM states:
  - IDLE: stage outputs are driven from the stage registers; for DMEM loads, extraction is applied to dmem_dout.
  - Accepting a valid, aligned MMIO load → WAIT.
  - WAIT: in_ready = 0. mmio_req[idx] = 1 only on the first WAIT cycle. Counter increments each cycle.
    - mmio_rvalid[idx] → capture rdata → RESP.
    - rvalid from other devices is ignored.
    - Counter reaches TIMEOUT_CYC−1 without rvalid → RESP with the error flag set.
  - RESP: one cycle. On success, rf_we = 1 (if rd ≠ 0) with the extracted captured data. On error, bus_err = 1 and rf_we = 0. in_ready = 1, so a new accept in this cycle goes to IDLE or WAIT.
- A late rvalid arriving in IDLE or RESP is ignored.
- rf_waddr always equals the rd of the stage registers.

## Timing
- Reset values:
  - state = IDLE, stage_valid = 0, counter = 0
  - rf_we = 0, mmio_req = 0, bus_err = 0
  - rf_wdata = 0, rf_waddr = 0, mmio_addr = 0
  - in_ready = 1
- Non-MMIO instructions: accepted at T, written at T+1 (combinational from the stage registers plus dmem_dout). Throughput is 1 per cycle.
- MMIO load: accepted at T, req at T+1, rvalid at W ≥ T+1, write at W+1. Next accept is possible at W+1.
- Timeout: with no response, bus_err fires at T+1+TIMEOUT_CYC.
- Asserting rst_n low mid-WAIT aborts immediately: no write, no error, and any pending response is dropped.
- in_ready is combinational: (state ≠ WAIT).

## Structure
- control_sel.vh gains WB_ALU, WB_MEM, WB_PC4 and WB_NONE, plus state encodings ST_IDLE, ST_WAIT and ST_RESP.
- Opcodes and funct3 codes come from opcode.vh.
- One sub-module, load_extract: combinational; inputs funct3, addr[1:0], raw word; outputs the extended word and a misalign flag.

## Test plan
- ADDI x5 followed by JAL x1 back-to-back → rf_we at T+1 (x5 = alu) and T+2 (x1 = pc4); in_ready stays 1.
- LB from DMEM, addr[1:0] = 3, dmem_dout = 0x80FF_FF12 → rf_wdata = 0xFFFF_FF80. LBU with the same inputs → 0x0000_0080.
- LW from 0x8000_0010 (device 1), rvalid after 5 cycles with rdata 0x1234_5678:
  - mmio_req = 2'b10 for one cycle.
  - in_ready low for 5 cycles.
  - Write 0x1234_5678 on the following cycle.
- MMIO load with no response → bus_err pulse at T+1+255, no rf_we, then a new instruction is accepted.
- LH with addr[0] = 1 → bus_err at T+1, rf_we = 0. A load with rd = x0 → rf_we = 0.
- Assert rst_n low during WAIT, then send rvalid after release → outputs at reset values, the response is ignored, and in_ready = 1.

Source files
------------

// File: rtl/wb_mmio_unit_pkg.sv
// Shared encodings for the writeback/MMIO stage:
// opcodes, load funct3 codes, writeback select and FSM states.
package wb_mmio_unit_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4,
    WB_NONE
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic wb_sel_e wb_class(
    input logic [6:0] op
  );
    wb_sel_e s;
    unique case (1'b1)
      (op == OP_REG),
      (op == OP_IMM),
      (op == OP_LUI),
      (op == OP_AUIPC): s = WB_ALU;
      (op == OP_JAL),
      (op == OP_JALR):  s = WB_PC4;
      (op == OP_LOAD):  s = WB_MEM;
      default:          s = WB_NONE;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    unique case (f3)
      F3_LH, F3_LHU: m = off[0];
      F3_LW:         m = (off != 2'b00);
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wb_mmio_unit_load_extract.sv
// Byte/half/word selection and extension of a load word,
// plus the alignment check for the access size.
module load_extract
  import wb_mmio_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext,
  output logic            misalign
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = raw[{off, 3'b000} +: 8];
  assign h = off[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    ext = raw;
    unique case (funct3)
      F3_LB:  ext = {{(XLEN-8){b[7]}}, b};
      F3_LBU: ext = {{(XLEN-8){1'b0}}, b};
      F3_LH:  ext = {{(XLEN-16){h[15]}}, h};
      F3_LHU: ext = {{(XLEN-16){1'b0}}, h};
      default: ext = raw;
    endcase
  end

  assign misalign = misaligned(funct3, off);

endmodule

// File: rtl/wb_mmio_unit.sv
// Registered writeback stage: ALU/PC+4/DMEM/MMIO select,
// load extraction, and a timed MMIO read handshake.
module wb_mmio_unit
  import wb_mmio_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int N_DEV       = 2,
  parameter int DEV_LSB     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_addr,
  input  logic [XLEN-1:0]       in_alu,
  input  logic [XLEN-1:0]       in_pc4,
  input  logic [XLEN-1:0]       dmem_dout,
  output logic [N_DEV-1:0]      mmio_req,
  output logic [XLEN-1:0]       mmio_addr,
  input  logic [N_DEV*XLEN-1:0] mmio_rdata,
  input  logic [N_DEV-1:0]      mmio_rvalid,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  bus_err
);

  localparam int IDXW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int CW   = $clog2(TIMEOUT_CYC + 1);

  function automatic int dev_of(
    input logic [XLEN-1:0] a
  );
    int d;
    d = 0;
    if (N_DEV > 1) d = int'(a[DEV_LSB +: IDXW]);
    return d;
  endfunction

  logic [14:0]     inst_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] pc4_q;
  logic            sv_q;

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] rdata_d;
  logic            err_q;
  logic            err_d;

  logic            accept;
  logic            in_go;
  wb_sel_e         cls;
  int              idx;
  logic            is_mmio;
  logic            bad_idx;
  logic            rv_sel;
  logic [XLEN-1:0] rd_sel;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] ext;
  logic            misal;
  logic            we_c;
  logic [XLEN-1:0] wd_c;
  logic            unused_inst;

  assign unused_inst = ^in_inst[31:15];

  assign in_ready = (state_q != ST_WAIT);
  assign accept   = in_valid && in_ready;

  // Only an aligned load to an existing device opens a bus transaction
  assign in_go = (in_inst[6:0] == OP_LOAD)
              && in_addr[XLEN-1]
              && !misaligned(in_inst[14:12], in_addr[1:0])
              && (dev_of(in_addr) < N_DEV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q   <= 1'b0;
      inst_q <= '0;
      addr_q <= '0;
      alu_q  <= '0;
      pc4_q  <= '0;
    end else begin
      sv_q <= accept;
      if (accept) begin
        inst_q <= in_inst[14:0];
        addr_q <= in_addr;
        alu_q  <= in_alu;
        pc4_q  <= in_pc4;
      end
    end
  end

  assign cls     = wb_class(inst_q[6:0]);
  assign idx     = dev_of(addr_q);
  assign is_mmio = addr_q[XLEN-1];
  assign bad_idx = (idx >= N_DEV);

  always_comb begin
    rv_sel = 1'b0;
    rd_sel = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (i == idx) begin
        rv_sel = mmio_rvalid[i];
        rd_sel = mmio_rdata[i*XLEN +: XLEN];
      end
    end
  end

  assign raw = (state_q == ST_RESP) ? rdata_q : dmem_dout;

  load_extract #(
    .XLEN(XLEN)
  ) u_ext (
    .funct3  (inst_q[14:12]),
    .off     (addr_q[1:0]),
    .raw     (raw),
    .ext     (ext),
    .misalign(misal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mmio_req = '0;
    we_c     = 1'b0;
    wd_c     = '0;
    bus_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sv_q) begin
          unique case (cls)
            WB_ALU: begin
              we_c = 1'b1;
              wd_c = alu_q;
            end
            WB_PC4: begin
              we_c = 1'b1;
              wd_c = pc4_q;
            end
            WB_MEM: begin
              if (misal || (is_mmio && bad_idx)) begin
                bus_err = 1'b1;
              end else if (!is_mmio) begin
                we_c = 1'b1;
                wd_c = ext;
              end
            end
            default: ;
          endcase
        end
        if (in_valid && in_go) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        for (int i = 0; i < N_DEV; i++) begin
          mmio_req[i] = (cnt_q == '0) && (i == idx);
        end
        if (rv_sel) begin
          rdata_d = rd_sel;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (err_q) begin
          bus_err = 1'b1;
        end else begin
          we_c = 1'b1;
          wd_c = ext;
        end
        state_d = (in_valid && in_go) ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rf_waddr  = inst_q[11:7];
  assign rf_we     = we_c && (inst_q[11:7] != 5'd0);
  assign rf_wdata  = rf_we ? wd_c : '0;
  assign mmio_addr = addr_q;

endmodule

// File: tb/tb_wb_mmio_unit.sv
// Directed and randomized bench for wb_mmio_unit against
// a spec-level reference model of the writeback rules.
module tb_wb_mmio_unit;

  localparam int XLEN = 32;
  localparam int NDEV = 2;
  localparam int TO   = 255;

  localparam logic [6:0] L_OP    = 7'h33;
  localparam logic [6:0] L_OPIMM = 7'h13;
  localparam logic [6:0] L_LUI   = 7'h37;
  localparam logic [6:0] L_AUIPC = 7'h17;
  localparam logic [6:0] L_JAL   = 7'h6f;
  localparam logic [6:0] L_JALR  = 7'h67;
  localparam logic [6:0] L_LOAD  = 7'h03;
  localparam logic [6:0] L_STORE = 7'h23;
  localparam logic [6:0] L_BR    = 7'h63;
  localparam logic [6:0] L_CUST  = 7'h0b;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_inst;
  logic [XLEN-1:0]      in_addr;
  logic [XLEN-1:0]      in_alu;
  logic [XLEN-1:0]      in_pc4;
  logic [XLEN-1:0]      dmem_dout;
  logic [NDEV-1:0]      mmio_req;
  logic [XLEN-1:0]      mmio_addr;
  logic [NDEV*XLEN-1:0] mmio_rdata;
  logic [NDEV-1:0]      mmio_rvalid;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 bus_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_mmio_unit #(
    .XLEN(XLEN),
    .N_DEV(NDEV),
    .DEV_LSB(4),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_addr    (in_addr),
    .in_alu     (in_alu),
    .in_pc4     (in_pc4),
    .dmem_dout  (dmem_dout),
    .mmio_req   (mmio_req),
    .mmio_addr  (mmio_addr),
    .mmio_rdata (mmio_rdata),
    .mmio_rvalid(mmio_rvalid),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .bus_err    (bus_err)
  );

  int nvec = 0;
  int nerr = 0;

  logic        prev_v;
  logic [31:0] prev_inst;
  logic [31:0] prev_addr;
  logic [31:0] prev_alu;
  logic [31:0] prev_pc4;
  logic [4:0]  last_rd;

  logic [2:0]  f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op,
                                     input logic [4:0] rd,
                                     input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    return {r[31:15], f3, rd, op};
  endfunction

  function automatic logic misal(input logic [2:0] f3,
                                 input logic [31:0] addr);
    int sz;
    sz = 1 << f3[1:0];
    return (int'(addr[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] f3,
                                         input logic [31:0] addr,
                                         input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] v;
    sh = word >> (8 * int'(addr[1:0]));
    case (f3[1:0])
      2'd0: v = f3[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1: v = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: v = word;
    endcase
    return v;
  endfunction

  // Expected writeback of a non-MMIO instruction one cycle after accept
  task automatic ref_wb(input logic [31:0] inst,
                        input logic [31:0] addr,
                        input logic [31:0] alu,
                        input logic [31:0] pc4,
                        input logic [31:0] word,
                        output logic we,
                        output logic [31:0] wd,
                        output logic err);
    logic [6:0] op;
    op  = inst[6:0];
    we  = 1'b0;
    wd  = 32'h0;
    err = 1'b0;
    if (op == L_OP || op == L_OPIMM || op == L_LUI || op == L_AUIPC) begin
      we = 1'b1;
      wd = alu;
    end else if (op == L_JAL || op == L_JALR) begin
      we = 1'b1;
      wd = pc4;
    end else if (op == L_LOAD) begin
      if (misal(inst[14:12], addr)) err = 1'b1;
      else begin
        we = 1'b1;
        wd = ld_val(inst[14:12], addr, word);
      end
    end
    if (inst[11:7] == 5'd0) we = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pstep(input logic v,
                       input logic [31:0] inst,
                       input logic [31:0] addr,
                       input logic [31:0] alu,
                       input logic [31:0] pc4,
                       input logic [31:0] dmem,
                       input logic den,
                       input logic [31:0] dwant);
    logic ew;
    logic [31:0] ewd;
    logic ee;
    in_valid    = v;
    in_inst     = inst;
    in_addr     = addr;
    in_alu      = alu;
    in_pc4      = pc4;
    dmem_dout   = dmem;
    mmio_rvalid = '0;
    ew  = 1'b0;
    ewd = 32'h0;
    ee  = 1'b0;
    if (prev_v)
      ref_wb(prev_inst, prev_addr, prev_alu, prev_pc4, dmem, ew, ewd, ee);
    @(negedge clk);
    chk("pipe_we", 32'(rf_we), 32'(ew));
    chk("pipe_err", 32'(bus_err), 32'(ee));
    chk("pipe_waddr", 32'(rf_waddr), 32'(last_rd));
    if (ew) chk("pipe_wdata", rf_wdata, ewd);
    if (den) chk("dir_wdata", rf_wdata, dwant);
    chk("pipe_rdy", 32'(in_ready), 32'd1);
    chk("pipe_req", 32'(mmio_req), 32'd0);
    prev_v = v;
    if (v) begin
      prev_inst = inst;
      prev_addr = addr;
      prev_alu  = alu;
      prev_pc4  = pc4;
      last_rd   = inst[11:7];
    end
    cyc();
  endtask

  task automatic idle_step();
    pstep(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, $urandom, 1'b0, 32'h0);
  endtask

  // lat = 0 means the device never answers
  task automatic mmio_txn(input logic [2:0] f3,
                          input logic [4:0] rd,
                          input logic [31:0] addr,
                          input int lat,
                          input logic [31:0] data);
    int dev;
    int n;
    logic [31:0] fa;
    dev = int'(addr[4]);
    n   = (lat == 0) ? TO : lat;
    fa  = $urandom;
    in_valid    = 1'b1;
    in_inst     = mk(L_LOAD, rd, f3);
    in_addr     = addr;
    in_alu      = addr;
    in_pc4      = $urandom;
    dmem_dout   = $urandom;
    mmio_rvalid = '0;
    @(negedge clk);
    chk("mm_acc_rdy", 32'(in_ready), 32'd1);
    chk("mm_acc_we", 32'(rf_we), 32'd0);
    cyc();
    in_inst = mk(L_OPIMM, 5'd7, 3'd0);
    in_alu  = fa;
    in_addr = $urandom;
    for (int j = 1; j <= n; j++) begin
      mmio_rvalid = '0;
      if (j == lat) begin
        mmio_rvalid[dev] = 1'b1;
        mmio_rdata[dev*32 +: 32] = data;
      end else if (j % 3 == 1) begin
        mmio_rvalid[1-dev] = 1'b1;
        mmio_rdata[(1-dev)*32 +: 32] = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      chk("mm_wait_rdy", 32'(in_ready), 32'd0);
      chk("mm_req", 32'(mmio_req), (j == 1) ? (32'd1 << dev) : 32'd0);
      chk("mm_wait_we", 32'(rf_we), 32'd0);
      chk("mm_wait_err", 32'(bus_err), 32'd0);
      chk("mm_addr", mmio_addr, addr);
      cyc();
    end
    mmio_rvalid = '0;
    mmio_rvalid[dev] = 1'b1;
    @(negedge clk);
    chk("mm_resp_err", 32'(bus_err), 32'(lat == 0));
    chk("mm_resp_we", 32'(rf_we), 32'((lat != 0) && (rd != 5'd0)));
    chk("mm_resp_waddr", 32'(rf_waddr), 32'(rd));
    if (lat != 0 && rd != 5'd0)
      chk("mm_resp_data", rf_wdata, ld_val(f3, addr, data));
    chk("mm_resp_rdy", 32'(in_ready), 32'd1);
    chk("mm_resp_req", 32'(mmio_req), 32'd0);
    cyc();
    in_valid    = 1'b0;
    mmio_rvalid = '0;
    @(negedge clk);
    chk("mm_next_we", 32'(rf_we), 32'd1);
    chk("mm_next_wdata", rf_wdata, fa);
    chk("mm_next_waddr", 32'(rf_waddr), 32'd7);
    chk("mm_next_err", 32'(bus_err), 32'd0);
    cyc();
    prev_v  = 1'b0;
    last_rd = 5'd7;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(rf_we), 32'd0);
    chk({tag, "_req"}, 32'(mmio_req), 32'd0);
    chk({tag, "_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_wdata"}, rf_wdata, 32'd0);
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
    chk({tag, "_maddr"}, mmio_addr, 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [6:0]  op;
    logic [4:0]  rd;
    int          k;
    int          dev;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_inst     = '0;
    in_addr     = '0;
    in_alu      = '0;
    in_pc4      = '0;
    dmem_dout   = '0;
    mmio_rdata  = '0;
    mmio_rvalid = '0;
    prev_v      = 1'b0;
    prev_inst   = '0;
    prev_addr   = '0;
    prev_alu    = '0;
    prev_pc4    = '0;
    last_rd     = '0;

    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    pstep(1'b1, mk(L_OPIMM, 5'd5, 3'd0), 32'h0, 32'h1111_2222,
          32'h0, 32'h0, 1'b0, 32'h0);
    pstep(1'b1, mk(L_JAL, 5'd1, 3'd0), 32'h0, 32'hAAAA_0000,
          32'h0000_1004, 32'h0, 1'b1, 32'h1111_2222);
    pstep(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
          1'b1, 32'h0000_1004);

    pstep(1'b1, mk(L_LOAD, 5'd3, 3'd0), 32'h0000_0103, 32'h0,
          32'h0, 32'h0, 1'b0, 32'h0);
    pstep(1'b1, mk(L_LOAD, 5'd4, 3'd4), 32'h0000_0103, 32'h0,
          32'h0, 32'h80FF_FF12, 1'b1, 32'hFFFF_FF80);
    pstep(1'b1, mk(L_LOAD, 5'd6, 3'd1), 32'h0000_0201, 32'h0,
          32'h0, 32'h80FF_FF12, 1'b1, 32'h0000_0080);
    pstep(1'b1, mk(L_LOAD, 5'd0, 3'd2), 32'h0000_0100, 32'h0,
          32'h0, $urandom, 1'b0, 32'h0);
    pstep(1'b1, mk(L_LOAD, 5'd8, 3'd2), 32'h8000_0012, 32'h0,
          32'h0, $urandom, 1'b0, 32'h0);
    idle_step();
    idle_step();

    mmio_txn(3'd2, 5'd9, 32'h8000_0010, 5, 32'h1234_5678);
    idle_step();
    mmio_txn(3'd2, 5'd11, 32'h8000_0000, 0, 32'h0);
    idle_step();

    in_valid = 1'b1;
    in_inst  = mk(L_LOAD, 5'd10, 3'd2);
    in_addr  = 32'h8000_0004;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rw_rdy", 32'(in_ready), 32'd0);
    chk("rw_req", 32'(mmio_req), 32'd1);
    cyc();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rw_mid");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    prev_v  = 1'b0;
    last_rd = 5'd0;
    mmio_rvalid[0] = 1'b1;
    mmio_rdata[31:0] = 32'hCAFE_F00D;
    @(negedge clk);
    chk_reset_vals("rw_late");
    cyc();
    mmio_rvalid = '0;
    @(negedge clk);
    chk_reset_vals("rw_after");
    cyc();

    for (int t = 0; t < 300; t++) begin
      k  = int'($urandom_range(0, 11));
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      f3 = 3'd0;
      a  = $urandom;
      case (k)
        0: op = L_OP;
        1: op = L_OPIMM;
        2: op = L_LUI;
        3: op = L_AUIPC;
        4: op = L_JAL;
        5: op = L_JALR;
        6: op = L_STORE;
        7: op = L_BR;
        8: op = L_CUST;
        default: begin
          op = L_LOAD;
          f3 = f3s[$urandom_range(0, 4)];
          a[31] = 1'b0;
        end
      endcase
      pstep(($urandom_range(0, 4) != 0), mk(op, rd, f3), a, $urandom,
            $urandom, $urandom, 1'b0, 32'h0);
    end
    idle_step();

    for (int t = 0; t < 10; t++) begin
      f3  = f3s[$urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'd1) off[0] = 1'b0;
      if (f3[1:0] == 2'd2) off = 2'd0;
      r   = $urandom;
      dev = int'($urandom_range(0, 1));
      a   = {1'b1, r[30:5], 1'(dev), r[3:2], off};
      idle_step();
      mmio_txn(f3, 5'($urandom_range(0, 31)), a,
               int'($urandom_range(1, 12)), $urandom);
    end
    idle_step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
